// File: rtl/cr_huf_comp_sym_histogram_if.sv
// Token-stream link from the upstream tokenizer into the symbol histogram.
// Carries two symbol lanes, frame tagging and the histogram's backpressure.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 6
`endif

`ifndef CR_HUF_COMP_PKG_DEFINED
`define CR_HUF_COMP_PKG_DEFINED
package cr_huf_comp_pkg;
  typedef enum logic [2:0] {
    MIDDLE    = 3'd0,
    EOB       = 3'd1,
    PASS_THRU = 3'd2,
    TRUNC     = 3'd3
  } e_pipe_eob;
endpackage
`endif

interface cr_huf_comp_sym_histogram_if
  import cr_huf_comp_pkg::*;
#(
  parameter int DAT_WIDTH   = 10,
  parameter int CNTRL_WIDTH = 1
);
  logic                              in_vld;
  logic                              in_sym0_vld;
  logic [DAT_WIDTH-1:0]              in_sym0;
  logic                              in_sym1_vld;
  logic [DAT_WIDTH-1:0]              in_sym1;
  logic [CNTRL_WIDTH-1:0]            in_meta;
  logic [`CREOLE_HC_SEQID_WIDTH-1:0] in_seq_id;
  e_pipe_eob                         in_eob;
  logic                              hist_not_ready;

  modport master (
    output in_vld, in_sym0_vld, in_sym0, in_sym1_vld, in_sym1,
           in_meta, in_seq_id, in_eob,
    input  hist_not_ready
  );

  modport slave (
    input  in_vld, in_sym0_vld, in_sym0, in_sym1_vld, in_sym1,
           in_meta, in_seq_id, in_eob,
    output hist_not_ready
  );
endinterface

// File: rtl/cr_huf_comp_sym_histogram.sv
// Per-frame symbol frequency histogram feeding the Huffman insertion sorter.
// Counts two symbols per beat, snapshots into a held bank at frame end, then pulses eob.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 6
`endif

`ifndef CR_HUF_COMP_PKG_DEFINED
`define CR_HUF_COMP_PKG_DEFINED
package cr_huf_comp_pkg;
  typedef enum logic [2:0] {
    MIDDLE    = 3'd0,
    EOB       = 3'd1,
    PASS_THRU = 3'd2,
    TRUNC     = 3'd3
  } e_pipe_eob;
endpackage
`endif

module cr_huf_comp_sym_histogram
  import cr_huf_comp_pkg::*;
#(
  parameter int DAT_WIDTH        = 10,
  parameter int SYM_FREQ_WIDTH   = 15,
  parameter int CNTRL_WIDTH      = 1,
  parameter int MAX_NUM_SYM_USED = 576
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  cr_huf_comp_sym_histogram_if.slave                       in_if,
  input  logic                                             is_not_ready,
  output logic [MAX_NUM_SYM_USED-1:0][SYM_FREQ_WIDTH-1:0]  new_freq,
  output logic [DAT_WIDTH-1:0]                             sym_lo,
  output logic [DAT_WIDTH-1:0]                             sym_hi,
  output logic [CNTRL_WIDTH-1:0]                           meta,
  output logic [`CREOLE_HC_SEQID_WIDTH-1:0]                seq_id,
  output e_pipe_eob                                        eob,
  output logic                                             hist_sym_err
);

  localparam logic [DAT_WIDTH:0]   NUM_SYM = (DAT_WIDTH+1)'(MAX_NUM_SYM_USED);
  localparam logic [DAT_WIDTH-1:0] SYM_TOP = DAT_WIDTH'(MAX_NUM_SYM_USED - 1);

  typedef enum logic {FREE, PEND} state_e;

  state_e                            state_q, state_d;
  e_pipe_eob                         eob_type_q;
  logic [DAT_WIDTH-1:0]              lo_q, hi_q, lo_t, hi_t;
  logic                              seen_q, seen_t;
  logic [DAT_WIDTH-1:0]              sym_lo_q, sym_hi_q;
  logic [CNTRL_WIDTH-1:0]            meta_q;
  logic [`CREOLE_HC_SEQID_WIDTH-1:0] seq_id_q;
  logic                              sym_err_q;

  logic emit, not_ready, beat_xfer, frame_end, pass_thru;
  logic lane0_ok, lane1_ok, cnt0, cnt1, err0, err1;

  // Stall only while an unsent snapshot is waiting; the emission cycle itself is open.
  assign emit      = (state_q == PEND) && !is_not_ready;
  assign not_ready = (state_q == PEND) && is_not_ready;
  assign in_if.hist_not_ready = not_ready;

  assign beat_xfer = in_if.in_vld && !not_ready;
  assign frame_end = beat_xfer && (in_if.in_eob != MIDDLE);
  assign pass_thru = in_if.in_eob == PASS_THRU;

  assign lane0_ok = {1'b0, in_if.in_sym0} < NUM_SYM;
  assign lane1_ok = {1'b0, in_if.in_sym1} < NUM_SYM;
  assign cnt0     = beat_xfer && in_if.in_sym0_vld && lane0_ok;
  assign cnt1     = beat_xfer && in_if.in_sym1_vld && lane1_ok;
  assign err0     = beat_xfer && in_if.in_sym0_vld && !lane0_ok;
  assign err1     = beat_xfer && in_if.in_sym1_vld && !lane1_ok;

  always_comb begin
    state_d = state_q;
    if (emit) state_d = FREE;
    if (frame_end) state_d = PEND;
  end

  always_comb begin
    lo_t   = lo_q;
    hi_t   = hi_q;
    seen_t = seen_q || cnt0 || cnt1;
    if (cnt0 && (in_if.in_sym0 < lo_t)) lo_t = in_if.in_sym0;
    if (cnt0 && (in_if.in_sym0 > hi_t)) hi_t = in_if.in_sym0;
    if (cnt1 && (in_if.in_sym1 < lo_t)) lo_t = in_if.in_sym1;
    if (cnt1 && (in_if.in_sym1 > hi_t)) hi_t = in_if.in_sym1;
  end

  // One saturating counter plus one held snapshot word per symbol.
  for (genvar gi = 0; gi < MAX_NUM_SYM_USED; gi++) begin : g_cnt
    localparam logic [DAT_WIDTH-1:0] IDX = DAT_WIDTH'(gi);
    logic [1:0]                inc;
    logic [SYM_FREQ_WIDTH:0]   sum;
    logic [SYM_FREQ_WIDTH-1:0] sat, cnt_q, bank_q;

    assign inc = {1'b0, cnt0 && (in_if.in_sym0 == IDX)} + {1'b0, cnt1 && (in_if.in_sym1 == IDX)};
    assign sum = {1'b0, cnt_q} + (SYM_FREQ_WIDTH+1)'(inc);
    assign sat = sum[SYM_FREQ_WIDTH] ? '1 : sum[SYM_FREQ_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        bank_q <= '0;
      end else if (frame_end) begin
        cnt_q  <= '0;
        bank_q <= pass_thru ? '0 : sat;
      end else begin
        cnt_q  <= sat;
      end
    end

    assign new_freq[gi] = bank_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FREE;
      eob_type_q <= MIDDLE;
      lo_q       <= SYM_TOP;
      hi_q       <= '0;
      seen_q     <= 1'b0;
      sym_lo_q   <= '0;
      sym_hi_q   <= '0;
      meta_q     <= '0;
      seq_id_q   <= '0;
      sym_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_err_q <= err0 || err1;
      if (frame_end) begin
        eob_type_q <= in_if.in_eob;
        sym_lo_q   <= (seen_t && !pass_thru) ? lo_t : '0;
        sym_hi_q   <= (seen_t && !pass_thru) ? hi_t : '0;
        meta_q     <= in_if.in_meta;
        seq_id_q   <= in_if.in_seq_id;
        lo_q       <= SYM_TOP;
        hi_q       <= '0;
        seen_q     <= 1'b0;
      end else begin
        lo_q   <= lo_t;
        hi_q   <= hi_t;
        seen_q <= seen_t;
      end
    end
  end

  assign eob          = emit ? eob_type_q : MIDDLE;
  assign sym_lo       = sym_lo_q;
  assign sym_hi       = sym_hi_q;
  assign meta         = meta_q;
  assign seq_id       = seq_id_q;
  assign hist_sym_err = sym_err_q;

endmodule

// File: tb/tb_cr_huf_comp_sym_histogram.sv
// Directed bench for the symbol histogram: counting, saturation, stall, back-to-back,
// pass-through, out-of-range symbols and reset while a snapshot is pending.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 6
`endif

module tb_cr_huf_comp_sym_histogram;
  import cr_huf_comp_pkg::*;

  localparam int DW = 10;
  localparam int FW = 15;
  localparam int CW = 1;
  localparam int NS = 576;
  localparam int SW = `CREOLE_HC_SEQID_WIDTH;

  logic                  clk;
  logic                  rst_n;
  logic                  is_not_ready;
  logic [NS-1:0][FW-1:0] new_freq;
  logic [NS-1:0][FW-1:0] exp_f;
  logic [DW-1:0]         sym_lo, sym_hi;
  logic [CW-1:0]         meta;
  logic [SW-1:0]         seq_id;
  e_pipe_eob             eob;
  logic                  hist_sym_err;
  int                    errors = 0;
  int                    checks = 0;
  int                    idx;

  cr_huf_comp_sym_histogram_if #(.DAT_WIDTH(DW), .CNTRL_WIDTH(CW)) hif ();

  cr_huf_comp_sym_histogram #(
    .DAT_WIDTH(DW), .SYM_FREQ_WIDTH(FW), .CNTRL_WIDTH(CW), .MAX_NUM_SYM_USED(NS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_if(hif), .is_not_ready(is_not_ready),
    .new_freq(new_freq), .sym_lo(sym_lo), .sym_hi(sym_hi), .meta(meta),
    .seq_id(seq_id), .eob(eob), .hist_sym_err(hist_sym_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int first_diff(input logic [NS-1:0][FW-1:0] a, input logic [NS-1:0][FW-1:0] b);
    for (int i = 0; i < NS; i++) if (a[i] !== b[i]) return i;
    return 0;
  endfunction

  task automatic drive(input logic v, input logic v0, input logic [DW-1:0] s0,
                       input logic v1, input logic [DW-1:0] s1, input e_pipe_eob e,
                       input logic [CW-1:0] m, input logic [SW-1:0] q);
    hif.in_vld = v; hif.in_sym0_vld = v0; hif.in_sym0 = s0;
    hif.in_sym1_vld = v1; hif.in_sym1 = s1; hif.in_eob = e;
    hif.in_meta = m; hif.in_seq_id = q;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, '0, MIDDLE, '0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; is_not_ready = 1'b0; idle();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    exp_f = '0;
    checks++; if (eob !== MIDDLE) begin errors++; $display("FAIL reset_eob: got %0d want %0d", eob, MIDDLE); end
    checks++; if (hif.hist_not_ready !== 1'b0) begin errors++; $display("FAIL reset_not_ready: got %b want 0", hif.hist_not_ready); end
    checks++; if (new_freq !== exp_f) begin errors++; idx = first_diff(new_freq, exp_f); $display("FAIL reset_freq: new_freq[%0d]=%0d want %0d", idx, new_freq[idx], exp_f[idx]); end
    checks++; if ({sym_lo, sym_hi, meta, seq_id, hist_sym_err} !== '0) begin errors++; $display("FAIL reset_outputs: lo=%0d hi=%0d meta=%0d seq=%0d err=%b want all 0", sym_lo, sym_hi, meta, seq_id, hist_sym_err); end
    $display("reset: eob=%0d not_ready=%b", eob, hif.hist_not_ready);
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b1, 10'd5, 1'b1, 10'd7, MIDDLE, 1'b0, 6'd0); tick();
    drive(1'b1, 1'b1, 10'd5, 1'b1, 10'd5, MIDDLE, 1'b0, 6'd0); tick();
    drive(1'b1, 1'b1, 10'd300, 1'b0, 10'd0, EOB, 1'b1, 6'd3); tick();
    idle();
    exp_f = '0; exp_f[5] = 15'd3; exp_f[7] = 15'd1; exp_f[300] = 15'd1;
    checks++; if (eob !== EOB) begin errors++; $display("FAIL basic_eob: got %0d want %0d", eob, EOB); end
    checks++; if (new_freq !== exp_f) begin errors++; idx = first_diff(new_freq, exp_f); $display("FAIL basic_freq: new_freq[%0d]=%0d want %0d", idx, new_freq[idx], exp_f[idx]); end
    checks++; if (sym_lo !== 10'd5 || sym_hi !== 10'd300) begin errors++; $display("FAIL basic_range: lo=%0d hi=%0d want 5 300", sym_lo, sym_hi); end
    checks++; if (meta !== 1'b1 || seq_id !== 6'd3) begin errors++; $display("FAIL basic_tag: meta=%0d seq=%0d want 1 3", meta, seq_id); end
    $display("basic: eob=%0d f5=%0d f7=%0d f300=%0d lo=%0d hi=%0d", eob, new_freq[5], new_freq[7], new_freq[300], sym_lo, sym_hi);
    tick();
    checks++; if (eob !== MIDDLE) begin errors++; $display("FAIL basic_pulse_len: got %0d want %0d", eob, MIDDLE); end
    checks++; if (new_freq !== exp_f) begin errors++; idx = first_diff(new_freq, exp_f); $display("FAIL basic_hold: new_freq[%0d]=%0d want %0d", idx, new_freq[idx], exp_f[idx]); end
  endtask

  task automatic test_saturation();
    // 16383 beats of {9,9} reach 32766, then the final +2 must clamp at 32767.
    drive(1'b1, 1'b1, 10'd9, 1'b1, 10'd9, MIDDLE, 1'b0, 6'd0);
    repeat (16383) tick();
    drive(1'b1, 1'b1, 10'd9, 1'b1, 10'd9, EOB, 1'b0, 6'd5); tick();
    idle();
    exp_f = '0; exp_f[9] = 15'd32767;
    checks++; if (eob !== EOB) begin errors++; $display("FAIL sat_eob: got %0d want %0d", eob, EOB); end
    checks++; if (new_freq !== exp_f) begin errors++; idx = first_diff(new_freq, exp_f); $display("FAIL sat_freq: new_freq[%0d]=%0d want %0d", idx, new_freq[idx], exp_f[idx]); end
    checks++; if (sym_lo !== 10'd9 || sym_hi !== 10'd9) begin errors++; $display("FAIL sat_range: lo=%0d hi=%0d want 9 9", sym_lo, sym_hi); end
    $display("saturation: f9=%0d", new_freq[9]);
    tick();
  endtask

  task automatic test_backpressure();
    is_not_ready = 1'b1;
    drive(1'b1, 1'b1, 10'd20, 1'b0, 10'd0, EOB, 1'b0, 6'd1); tick();
    drive(1'b1, 1'b1, 10'd21, 1'b1, 10'd21, MIDDLE, 1'b0, 6'd0);
    for (int i = 0; i < 10; i++) begin
      checks++; if (hif.hist_not_ready !== 1'b1 || eob !== MIDDLE) begin errors++; $display("FAIL bp_wait%0d: not_ready=%b eob=%0d want 1 %0d", i, hif.hist_not_ready, eob, MIDDLE); end
      tick();
    end
    is_not_ready = 1'b0;
    #1;
    exp_f = '0; exp_f[20] = 15'd1;
    checks++; if (eob !== EOB || hif.hist_not_ready !== 1'b0) begin errors++; $display("FAIL bp_emit: eob=%0d not_ready=%b want %0d 0", eob, hif.hist_not_ready, EOB); end
    checks++; if (new_freq !== exp_f) begin errors++; idx = first_diff(new_freq, exp_f); $display("FAIL bp_freq1: new_freq[%0d]=%0d want %0d", idx, new_freq[idx], exp_f[idx]); end
    checks++; if (seq_id !== 6'd1 || sym_lo !== 10'd20 || sym_hi !== 10'd20) begin errors++; $display("FAIL bp_tag1: seq=%0d lo=%0d hi=%0d want 1 20 20", seq_id, sym_lo, sym_hi); end
    $display("backpressure: frame1 eob=%0d f20=%0d f21=%0d", eob, new_freq[20], new_freq[21]);
    tick();
    drive(1'b1, 1'b1, 10'd22, 1'b0, 10'd0, EOB, 1'b1, 6'd2); tick();
    idle();
    exp_f = '0; exp_f[21] = 15'd2; exp_f[22] = 15'd1;
    checks++; if (eob !== EOB) begin errors++; $display("FAIL bp_eob2: got %0d want %0d", eob, EOB); end
    checks++; if (new_freq !== exp_f) begin errors++; idx = first_diff(new_freq, exp_f); $display("FAIL bp_freq2: new_freq[%0d]=%0d want %0d", idx, new_freq[idx], exp_f[idx]); end
    checks++; if (seq_id !== 6'd2 || meta !== 1'b1 || sym_lo !== 10'd21 || sym_hi !== 10'd22) begin errors++; $display("FAIL bp_tag2: seq=%0d meta=%0d lo=%0d hi=%0d want 2 1 21 22", seq_id, meta, sym_lo, sym_hi); end
    $display("backpressure: frame2 eob=%0d f21=%0d f22=%0d", eob, new_freq[21], new_freq[22]);
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 10'd40, 1'b1, 10'd41, EOB, 1'b0, 6'd4); tick();
    exp_f = '0; exp_f[40] = 15'd1; exp_f[41] = 15'd1;
    checks++; if (eob !== EOB || hif.hist_not_ready !== 1'b0) begin errors++; $display("FAIL b2b_eob1: eob=%0d not_ready=%b want %0d 0", eob, hif.hist_not_ready, EOB); end
    checks++; if (new_freq !== exp_f || seq_id !== 6'd4 || sym_lo !== 10'd40 || sym_hi !== 10'd41) begin errors++; idx = first_diff(new_freq, exp_f); $display("FAIL b2b_snap1: f[%0d]=%0d want %0d seq=%0d lo=%0d hi=%0d want 4 40 41", idx, new_freq[idx], exp_f[idx], seq_id, sym_lo, sym_hi); end
    $display("b2b: frame seq=%0d eob=%0d", seq_id, eob);
    drive(1'b1, 1'b1, 10'd50, 1'b0, 10'd0, EOB, 1'b1, 6'd5); tick();
    exp_f = '0; exp_f[50] = 15'd1;
    checks++; if (eob !== EOB) begin errors++; $display("FAIL b2b_eob2: got %0d want %0d", eob, EOB); end
    checks++; if (new_freq !== exp_f || seq_id !== 6'd5 || meta !== 1'b1 || sym_lo !== 10'd50 || sym_hi !== 10'd50) begin errors++; idx = first_diff(new_freq, exp_f); $display("FAIL b2b_snap2: f[%0d]=%0d want %0d seq=%0d lo=%0d hi=%0d want 5 50 50", idx, new_freq[idx], exp_f[idx], seq_id, sym_lo, sym_hi); end
    $display("b2b: frame seq=%0d eob=%0d", seq_id, eob);
    drive(1'b1, 1'b0, 10'd0, 1'b1, 10'd60, EOB, 1'b0, 6'd6); tick();
    idle();
    exp_f = '0; exp_f[60] = 15'd1;
    checks++; if (eob !== EOB) begin errors++; $display("FAIL b2b_eob3: got %0d want %0d", eob, EOB); end
    checks++; if (new_freq !== exp_f || seq_id !== 6'd6 || sym_lo !== 10'd60 || sym_hi !== 10'd60) begin errors++; idx = first_diff(new_freq, exp_f); $display("FAIL b2b_snap3: f[%0d]=%0d want %0d seq=%0d lo=%0d hi=%0d want 6 60 60", idx, new_freq[idx], exp_f[idx], seq_id, sym_lo, sym_hi); end
    $display("b2b: frame seq=%0d eob=%0d", seq_id, eob);
    tick();
    checks++; if (eob !== MIDDLE) begin errors++; $display("FAIL b2b_idle: got %0d want %0d", eob, MIDDLE); end
  endtask

  task automatic test_pass_thru();
    drive(1'b1, 1'b1, 10'd3, 1'b1, 10'd4, MIDDLE, 1'b0, 6'd0); tick();
    drive(1'b1, 1'b1, 10'd1, 1'b1, 10'd2, PASS_THRU, 1'b1, 6'd7); tick();
    idle();
    exp_f = '0;
    checks++; if (eob !== PASS_THRU) begin errors++; $display("FAIL pt_eob: got %0d want %0d", eob, PASS_THRU); end
    checks++; if (new_freq !== exp_f) begin errors++; idx = first_diff(new_freq, exp_f); $display("FAIL pt_freq: new_freq[%0d]=%0d want %0d", idx, new_freq[idx], exp_f[idx]); end
    checks++; if (sym_lo !== 10'd0 || sym_hi !== 10'd0 || seq_id !== 6'd7) begin errors++; $display("FAIL pt_tag: lo=%0d hi=%0d seq=%0d want 0 0 7", sym_lo, sym_hi, seq_id); end
    $display("pass_thru: eob=%0d lo=%0d hi=%0d", eob, sym_lo, sym_hi);
    tick();
    // An empty frame right after shows the pass-through frame left nothing behind.
    drive(1'b1, 1'b0, 10'd0, 1'b0, 10'd0, EOB, 1'b0, 6'd8); tick();
    idle();
    checks++; if (eob !== EOB || new_freq !== exp_f) begin errors++; idx = first_diff(new_freq, exp_f); $display("FAIL empty_frame: eob=%0d f[%0d]=%0d want %0d 0", eob, idx, new_freq[idx], EOB); end
    checks++; if (sym_lo !== 10'd0 || sym_hi !== 10'd0) begin errors++; $display("FAIL empty_range: lo=%0d hi=%0d want 0 0", sym_lo, sym_hi); end
    $display("empty: eob=%0d seq=%0d", eob, seq_id);
    tick();
  endtask

  task automatic test_sym_err_reset();
    drive(1'b1, 1'b1, 10'd10, 1'b1, 10'd600, MIDDLE, 1'b0, 6'd0); tick();
    idle();
    checks++; if (hist_sym_err !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b want 1", hist_sym_err); end
    tick();
    checks++; if (hist_sym_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", hist_sym_err); end
    is_not_ready = 1'b1;
    drive(1'b1, 1'b0, 10'd0, 1'b0, 10'd0, EOB, 1'b0, 6'd9); tick();
    idle();
    exp_f = '0; exp_f[10] = 15'd1;
    checks++; if (new_freq !== exp_f) begin errors++; idx = first_diff(new_freq, exp_f); $display("FAIL err_freq: new_freq[%0d]=%0d want %0d", idx, new_freq[idx], exp_f[idx]); end
    checks++; if (sym_lo !== 10'd10 || sym_hi !== 10'd10) begin errors++; $display("FAIL err_range: lo=%0d hi=%0d want 10 10", sym_lo, sym_hi); end
    checks++; if (eob !== MIDDLE || hif.hist_not_ready !== 1'b1) begin errors++; $display("FAIL err_pend: eob=%0d not_ready=%b want %0d 1", eob, hif.hist_not_ready, MIDDLE); end
    $display("sym_err: f10=%0d lo=%0d hi=%0d pending", new_freq[10], sym_lo, sym_hi);
    rst_n = 1'b0;
    #1;
    exp_f = '0;
    checks++; if (eob !== MIDDLE || hif.hist_not_ready !== 1'b0) begin errors++; $display("FAIL rst_pend: eob=%0d not_ready=%b want %0d 0", eob, hif.hist_not_ready, MIDDLE); end
    checks++; if (new_freq !== exp_f || sym_lo !== 10'd0 || seq_id !== 6'd0) begin errors++; idx = first_diff(new_freq, exp_f); $display("FAIL rst_bank: f[%0d]=%0d lo=%0d seq=%0d want 0", idx, new_freq[idx], sym_lo, seq_id); end
    tick();
    rst_n = 1'b1;
    is_not_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (eob !== MIDDLE) begin errors++; $display("FAIL rst_no_emit%0d: got %0d want %0d", i, eob, MIDDLE); end
    end
    $display("reset_mid_pend: eob=%0d not_ready=%b", eob, hif.hist_not_ready);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_pass_thru();
    test_sym_err_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
